// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
// Holds the FSM states, the access-owner tags and the counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select: data priority with a fetch starvation override.
// Also computes the next value of the starvation counter.
module arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic             if_req,
   input  logic             if_ready,
   input  logic             dm_req,
   input  logic             dm_ready,
   input  logic [CNT_W-1:0] starve_cnt,
   output logic             grant_if,
   output logic             grant_dm,
   output logic [CNT_W-1:0] starve_next
);

   logic if_elig;
   logic dm_elig;
   logic starved;

   always_comb begin
      // A requester whose ready is high this cycle is only showing its old request.
      if_elig     = if_req & ~if_ready;
      dm_elig     = dm_req & ~dm_ready;
      starved     = if_elig && (starve_cnt == CNT_W'(STARVE_MAX));
      grant_dm    = dm_elig & ~starved;
      grant_if    = if_elig & ~grant_dm;
      starve_next = starve_cnt;
      if (grant_if) begin
         starve_next = '0;
      end else if (grant_dm && if_elig) begin
         starve_next = (starve_cnt >= CNT_W'(STARVE_MAX)) ? CNT_W'(STARVE_MAX)
                                                          : starve_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// the MEM-stage data port; one access outstanding, one-cycle ready pulses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LATENCY    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ready,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t            state_reg, state_next;
   owner_t            owner_reg, owner_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [CNT_W-1:0]  starve_reg, starve_next;
   logic              we_reg, we_next;
   logic              ram_en_reg, ram_en_next;
   logic              ram_we_reg, ram_we_next;
   logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
   logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
   logic              if_ready_reg, if_ready_next;
   logic              dm_ready_reg, dm_ready_next;
   logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
   logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
   logic              grant_if, grant_dm;
   logic [CNT_W-1:0]  pick_starve;

   arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .if_req      (if_req),
      .if_ready    (if_ready_reg),
      .dm_req      (dm_req),
      .dm_ready    (dm_ready_reg),
      .starve_cnt  (starve_reg),
      .grant_if    (grant_if),
      .grant_dm    (grant_dm),
      .starve_next (pick_starve)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         owner_reg     <= OWN_NONE;
         cnt_reg       <= '0;
         starve_reg    <= '0;
         we_reg        <= 1'b0;
         ram_en_reg    <= 1'b0;
         ram_we_reg    <= 1'b0;
         ram_addr_reg  <= '0;
         ram_wdata_reg <= '0;
         if_ready_reg  <= 1'b0;
         dm_ready_reg  <= 1'b0;
         if_rdata_reg  <= '0;
         dm_rdata_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         owner_reg     <= owner_next;
         cnt_reg       <= cnt_next;
         starve_reg    <= starve_next;
         we_reg        <= we_next;
         ram_en_reg    <= ram_en_next;
         ram_we_reg    <= ram_we_next;
         ram_addr_reg  <= ram_addr_next;
         ram_wdata_reg <= ram_wdata_next;
         if_ready_reg  <= if_ready_next;
         dm_ready_reg  <= dm_ready_next;
         if_rdata_reg  <= if_rdata_next;
         dm_rdata_reg  <= dm_rdata_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      owner_next     = owner_reg;
      cnt_next       = cnt_reg;
      starve_next    = starve_reg;
      we_next        = we_reg;
      ram_en_next    = 1'b0;
      ram_we_next    = 1'b0;
      ram_addr_next  = ram_addr_reg;
      ram_wdata_next = ram_wdata_reg;
      if_ready_next  = 1'b0;
      dm_ready_next  = 1'b0;
      if_rdata_next  = if_rdata_reg;
      dm_rdata_next  = dm_rdata_reg;
      case (state_reg)
         ST_IDLE: begin
            if (grant_dm || grant_if) begin
               ram_en_next    = 1'b1;
               ram_we_next    = grant_dm & dm_we;
               we_next        = grant_dm & dm_we;
               ram_addr_next  = grant_dm ? dm_addr : if_addr;
               // Write data is don't-care for reads, so it is captured unconditionally.
               ram_wdata_next = dm_wdata;
               owner_next     = grant_dm ? OWN_DM : OWN_IF;
               starve_next    = pick_starve;
               state_next     = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            cnt_next   = CNT_W'(LATENCY - 1);
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_reg == '0) begin
               if (owner_reg == OWN_DM) begin
                  dm_ready_next = 1'b1;
                  if (!we_reg) dm_rdata_next = ram_rdata;
               end else if (owner_reg == OWN_IF) begin
                  if_ready_next = 1'b1;
                  if_rdata_next = ram_rdata;
               end
               owner_next = OWN_NONE;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            owner_next = OWN_NONE;
         end
      endcase
   end

   assign ram_en    = ram_en_reg;
   assign ram_we    = ram_we_reg;
   assign ram_addr  = ram_addr_reg;
   assign ram_wdata = ram_wdata_reg;
   assign if_ready  = if_ready_reg;
   assign dm_ready  = dm_ready_reg;
   assign if_rdata  = if_rdata_reg;
   assign dm_rdata  = dm_rdata_reg;

endmodule
